// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer and reservation stations.
// Sizes, tag sentinel and the ROB entry layout live here.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 5;
  localparam int XLEN      = 32;

  // Tag value meaning "operand has no producer in flight"
  localparam logic [TAG_W-1:0] NO_DEP_TAG = 5'h1f;

  localparam int RS_DEPTH = 8;
  localparam int RS_OP_W  = 4;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
    logic            mispredict;
    logic [XLEN-1:0] target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_query_port.sv
// Operand lookup into the ROB by tag for the issue stage.
// ROB_BYPASS_EN adds same-cycle forwarding from the writeback bus.
module rob_query_port
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic [TAG_W-1:0]            qry_tag,
  input  logic [DEPTH-1:0]            ent_valid,
  input  logic [DEPTH-1:0]            ent_ready,
  input  logic [DEPTH-1:0][XLEN-1:0]  ent_val,
`ifdef ROB_BYPASS_EN
  input  logic                        wb_en,
  input  logic [TAG_W-1:0]            wb_tag,
  input  logic [XLEN-1:0]             wb_val,
`endif
  output logic                        qry_ready,
  output logic [XLEN-1:0]             qry_val
);

  localparam int IW = $clog2(DEPTH);

  logic [IW-1:0] idx;
  logic          in_rng;

  assign idx    = qry_tag[IW-1:0];
  assign in_rng = int'(qry_tag) < DEPTH;

  always_comb begin
    qry_ready = 1'b0;
    qry_val   = '0;
    if (in_rng && ent_valid[idx] && ent_ready[idx]) begin
      qry_ready = 1'b1;
      qry_val   = ent_val[idx];
    end
`ifdef ROB_BYPASS_EN
    if (in_rng && ent_valid[idx] && wb_en && wb_tag == qry_tag) begin
      qry_ready = 1'b1;
      qry_val   = wb_val;
    end
`endif
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order commit, mispredict flush, tag lookup.
// Define ROB_BYPASS_EN for writeback-to-query forwarding.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             issue_en,
  input  logic [4:0]       issue_rd,
  output logic             rob_full,
  output logic [TAG_W-1:0] rob_tag_o,
  input  logic [TAG_W-1:0] qry1_tag,
  input  logic [TAG_W-1:0] qry2_tag,
  output logic             qry1_ready,
  output logic             qry2_ready,
  output logic [XLEN-1:0]  qry1_val,
  output logic [XLEN-1:0]  qry2_val,
  input  logic             wb_en,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [XLEN-1:0]  wb_val,
  input  logic             wb_mispredict,
  input  logic [XLEN-1:0]  wb_target,
  output logic             commit_en,
  output logic [TAG_W-1:0] commit_Number,
  output logic [XLEN-1:0]  commit_val,
  output logic [4:0]       commit_rd,
  output logic             clear_o,
  output logic [XLEN-1:0]  clear_pc
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  rob_entry_t rob_q [DEPTH];
  rob_entry_t rob_d [DEPTH];

  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic             commit_en_q, commit_en_d;
  logic [TAG_W-1:0] commit_num_q, commit_num_d;
  logic [XLEN-1:0]  commit_val_q, commit_val_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic             clear_o_q, clear_o_d;
  logic [XLEN-1:0]  clear_pc_q, clear_pc_d;

  logic          do_issue;
  logic          do_commit;
  logic          wb_hit;
  logic [IW-1:0] wb_idx;
  rob_entry_t    head_ent;

  logic [DEPTH-1:0]           ent_valid;
  logic [DEPTH-1:0]           ent_ready;
  logic [DEPTH-1:0][XLEN-1:0] ent_val;

  assign rob_full  = count_q == CW'(DEPTH);
  assign rob_tag_o = TAG_W'(tail_q);

  assign head_ent  = rob_q[head_q];
  assign do_issue  = issue_en && !rob_full;
  assign do_commit = head_ent.valid && head_ent.ready;
  assign wb_idx    = wb_tag[IW-1:0];
  assign wb_hit    = wb_en && (int'(wb_tag) < DEPTH)
                     && rob_q[wb_idx].valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = rob_q[i].valid;
      ent_ready[i] = rob_q[i].ready;
      ent_val[i]   = rob_q[i].val;
    end
  end

  always_comb begin
    rob_d        = rob_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    commit_en_d  = 1'b0;
    commit_num_d = commit_num_q;
    commit_val_d = commit_val_q;
    commit_rd_d  = commit_rd_q;
    clear_o_d    = 1'b0;
    clear_pc_d   = clear_pc_q;

    if (rdy_in) begin
      if (clear || (do_commit && head_ent.mispredict)) begin
        if (!clear) begin
          commit_en_d  = 1'b1;
          commit_num_d = TAG_W'(head_q);
          commit_val_d = head_ent.val;
          commit_rd_d  = head_ent.rd;
          clear_o_d    = 1'b1;
          clear_pc_d   = head_ent.target;
        end
        for (int i = 0; i < DEPTH; i++) begin
          rob_d[i].valid = 1'b0;
          rob_d[i].ready = 1'b0;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (wb_hit) begin
          rob_d[wb_idx].ready      = 1'b1;
          rob_d[wb_idx].val        = wb_val;
          rob_d[wb_idx].mispredict = wb_mispredict;
          rob_d[wb_idx].target     = wb_target;
        end
        if (do_issue) begin
          rob_d[tail_q].valid      = 1'b1;
          rob_d[tail_q].ready      = 1'b0;
          rob_d[tail_q].rd         = issue_rd;
          rob_d[tail_q].mispredict = 1'b0;
          tail_d = tail_q + IW'(1);
        end
        // Commit sees only ready bits stored at an earlier edge
        if (do_commit) begin
          commit_en_d  = 1'b1;
          commit_num_d = TAG_W'(head_q);
          commit_val_d = head_ent.val;
          commit_rd_d  = head_ent.rd;
          rob_d[head_q].valid = 1'b0;
          rob_d[head_q].ready = 1'b0;
          head_d = head_q + IW'(1);
        end
        unique case ({do_issue, do_commit})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_en_q  <= 1'b0;
      commit_num_q <= '0;
      commit_val_q <= '0;
      commit_rd_q  <= '0;
      clear_o_q    <= 1'b0;
      clear_pc_q   <= '0;
    end else begin
      rob_q        <= rob_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      commit_en_q  <= commit_en_d;
      commit_num_q <= commit_num_d;
      commit_val_q <= commit_val_d;
      commit_rd_q  <= commit_rd_d;
      clear_o_q    <= clear_o_d;
      clear_pc_q   <= clear_pc_d;
    end
  end

  assign commit_en     = commit_en_q;
  assign commit_Number = commit_num_q;
  assign commit_val    = commit_val_q;
  assign commit_rd     = commit_rd_q;
  assign clear_o       = clear_o_q;
  assign clear_pc      = clear_pc_q;

  rob_query_port #(.DEPTH(DEPTH)) u_qry1 (
    .qry_tag   (qry1_tag),
    .ent_valid (ent_valid),
    .ent_ready (ent_ready),
    .ent_val   (ent_val),
`ifdef ROB_BYPASS_EN
    .wb_en     (wb_en),
    .wb_tag    (wb_tag),
    .wb_val    (wb_val),
`endif
    .qry_ready (qry1_ready),
    .qry_val   (qry1_val)
  );

  rob_query_port #(.DEPTH(DEPTH)) u_qry2 (
    .qry_tag   (qry2_tag),
    .ent_valid (ent_valid),
    .ent_ready (ent_ready),
    .ent_val   (ent_val),
`ifdef ROB_BYPASS_EN
    .wb_en     (wb_en),
    .wb_tag    (wb_tag),
    .wb_val    (wb_val),
`endif
    .qry_ready (qry2_ready),
    .qry_val   (qry2_val)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (DEPTH=16).
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        rob_full;
  logic [4:0]  rob_tag_o;
  logic [4:0]  qry1_tag, qry2_tag;
  logic        qry1_ready, qry2_ready;
  logic [31:0] qry1_val, qry2_val;
  logic        wb_en;
  logic [4:0]  wb_tag;
  logic [31:0] wb_val;
  logic        wb_mispredict;
  logic [31:0] wb_target;
  logic        commit_en;
  logic [4:0]  commit_Number;
  logic [31:0] commit_val;
  logic [4:0]  commit_rd;
  logic        clear_o;
  logic [31:0] clear_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.DEPTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .rob_full(rob_full), .rob_tag_o(rob_tag_o),
    .qry1_tag(qry1_tag), .qry2_tag(qry2_tag),
    .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
    .qry1_val(qry1_val), .qry2_val(qry2_val),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_val(wb_val),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .commit_en(commit_en), .commit_Number(commit_Number),
    .commit_val(commit_val), .commit_rd(commit_rd),
    .clear_o(clear_o), .clear_pc(clear_pc)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_commit(input string tag, input logic [4:0] num,
                            input logic [31:0] val, input logic [4:0] rd);
    chk({tag, "_en"}, 32'(commit_en), 32'd1);
    chk({tag, "_num"}, 32'(commit_Number), 32'(num));
    chk({tag, "_val"}, commit_val, val);
    chk({tag, "_rd"}, 32'(commit_rd), 32'(rd));
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    issue_en = 1'b0; issue_rd = '0;
    qry1_tag = '0; qry2_tag = '0;
    wb_en = 1'b0; wb_tag = '0; wb_val = '0;
    wb_mispredict = 1'b0; wb_target = '0;

    // reset
    step();
    rst_in = 1'b1;
    chk("rst_tag", 32'(rob_tag_o), 0);
    chk("rst_full", 32'(rob_full), 0);
    chk("rst_commit", 32'(commit_en), 0);
    chk("rst_clear", 32'(clear_o), 0);
    chk("rst_num", 32'(commit_Number), 0);
    chk("rst_pc", clear_pc, 0);

    // in-order commit
    issue_en = 1'b1;
    issue_rd = 5'd5; step();
    chk("iss_tag1", 32'(rob_tag_o), 1);
    issue_rd = 5'd6; step();
    issue_rd = 5'd7; step();
    chk("iss_tag3", 32'(rob_tag_o), 3);
    issue_en = 1'b0;
    wb_en = 1'b1; wb_tag = 5'd2; wb_val = 32'h30; step();
    wb_tag = 5'd0; wb_val = 32'h10;
    qry1_tag = 5'd2;
    #1;
    chk("qry_t2_rdy", 32'(qry1_ready), 1);
    chk("qry_t2_val", qry1_val, 32'h30);
    step();
    chk("no_commit_yet", 32'(commit_en), 0);
    wb_tag = 5'd1; wb_val = 32'h20; step();
    chk_commit("c0", 5'd0, 32'h10, 5'd5);
    wb_en = 1'b0; step();
    chk_commit("c1", 5'd1, 32'h20, 5'd6);
    step();
    chk_commit("c2", 5'd2, 32'h30, 5'd7);
    step();
    chk("c_done", 32'(commit_en), 0);
    chk("c_tag", 32'(rob_tag_o), 3);

    // full and wrap
    do_reset();
    issue_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue_rd = 5'(i);
      step();
    end
    chk("full_set", 32'(rob_full), 1);
    chk("full_tag", 32'(rob_tag_o), 0);
    issue_rd = 5'd31; step();
    chk("full_ign_tag", 32'(rob_tag_o), 0);
    chk("full_ign_full", 32'(rob_full), 1);
    issue_en = 1'b0;
    wb_en = 1'b1; wb_tag = 5'd0; wb_val = 32'h55; step();
    wb_en = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd31; step();
    chk_commit("wc0", 5'd0, 32'h55, 5'd0);
    chk("wc_tag", 32'(rob_tag_o), 0);
    chk("wc_full", 32'(rob_full), 0);
    issue_rd = 5'd9; step();
    issue_en = 1'b0;
    chk("wrap_tag", 32'(rob_tag_o), 1);
    chk("wrap_full", 32'(rob_full), 1);
    chk("wrap_nocommit", 32'(commit_en), 0);

    // mispredict flush
    do_reset();
    issue_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      issue_rd = 5'(i);
      step();
    end
    issue_en = 1'b0;
    wb_en = 1'b1; wb_tag = 5'd0; wb_val = 32'h77;
    wb_mispredict = 1'b1; wb_target = 32'h1000; step();
    wb_en = 1'b0; wb_mispredict = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd4; step();
    issue_en = 1'b0;
    chk_commit("mp", 5'd0, 32'h77, 5'd1);
    chk("mp_clear", 32'(clear_o), 1);
    chk("mp_pc", clear_pc, 32'h1000);
    chk("mp_tag", 32'(rob_tag_o), 0);
    chk("mp_full", 32'(rob_full), 0);
    wb_en = 1'b1; wb_tag = 5'd1; wb_val = 32'h20; step();
    chk("mp_clear_drop", 32'(clear_o), 0);
    chk("mp_nc1", 32'(commit_en), 0);
    wb_tag = 5'd2; step();
    chk("mp_nc2", 32'(commit_en), 0);
    wb_en = 1'b0;
    qry1_tag = 5'd1;
    step();
    chk("mp_nc3", 32'(commit_en), 0);
    chk("mp_qry", 32'(qry1_ready), 0);
    step();
    chk("mp_nc4", 32'(commit_en), 0);

    // bypass
    do_reset();
    issue_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_rd = 5'(10 + i);
      step();
    end
    issue_en = 1'b0;
    qry1_tag = 5'd3; qry2_tag = 5'd3;
    wb_en = 1'b1; wb_tag = 5'd3; wb_val = 32'hABCD;
    #1;
`ifdef ROB_BYPASS_EN
    chk("byp_rdy", 32'(qry1_ready), 1);
    chk("byp_val", qry1_val, 32'hABCD);
`else
    chk("byp_rdy", 32'(qry1_ready), 0);
    chk("byp_val", qry1_val, 0);
`endif
    step();
    wb_en = 1'b0;
    #1;
    chk("stored_rdy", 32'(qry2_ready), 1);
    chk("stored_val", qry2_val, 32'hABCD);

    // stall
    wb_en = 1'b1; wb_tag = 5'd0; wb_val = 32'h11; step();
    wb_en = 1'b0;
    rdy_in = 1'b0; issue_en = 1'b1; issue_rd = 5'd20;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_nc", 32'(commit_en), 0);
      chk("stall_tag", 32'(rob_tag_o), 4);
    end
    rdy_in = 1'b1; issue_en = 1'b0; step();
    chk_commit("stall_c", 5'd0, 32'h11, 5'd10);
    step();
    chk("stall_single", 32'(commit_en), 0);

    // external clear
    clear = 1'b1; step();
    clear = 1'b0;
    chk("clr_nc", 32'(commit_en), 0);
    chk("clr_clear_o", 32'(clear_o), 0);
    chk("clr_tag", 32'(rob_tag_o), 0);
    chk("clr_qry", 32'(qry2_ready), 0);

    // reset mid-operation
    issue_en = 1'b1; issue_rd = 5'd3; step();
    issue_en = 1'b0;
    wb_en = 1'b1; wb_tag = 5'd0; wb_val = 32'h99; step();
    wb_en = 1'b0;
    rst_in = 1'b0; step();
    chk("mid_rst_nc", 32'(commit_en), 0);
    chk("mid_rst_tag", 32'(rob_tag_o), 0);
    rst_in = 1'b1; step();
    chk("mid_rst_nc2", 32'(commit_en), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries, power of two, 2..32.
REQ-002 SHALL have ports clk_in input 1 (clock) and rst_in input 1 (reset, synchronous, active-low).
REQ-003 SHALL have ports rdy_in input 1 (global stall when low) and clear input 1 (external flush request).
REQ-004 SHALL have ports issue_en input 1, issue_rd input 5 (destination architectural register), rob_full output 1, rob_tag_o output 5 (tag the next issue receives).
REQ-005 SHALL have ports qry1_tag/qry2_tag input 5, qry1_ready/qry2_ready output 1, qry1_val/qry2_val output 32 (operand lookup for issue).
REQ-006 SHALL have ports wb_en input 1, wb_tag input 5, wb_val input 32, wb_mispredict input 1, wb_target input 32 (ALU writeback).
REQ-007 SHALL have ports commit_en output 1, commit_Number output 5, commit_val output 32, commit_rd output 5 (to RS and register file).
REQ-008 SHALL have ports clear_o output 1 and clear_pc output 32 (flush broadcast and redirect PC).

Function
REQ-009 SHALL hold a circular buffer of DEPTH entries (valid, ready, rd, value, mispredict, target) with head, tail and count; tags are entry indices 0..DEPTH-1.
REQ-010 SHALL drive rob_tag_o = tail and rob_full = (count == DEPTH) combinationally from current state.
REQ-011 SHALL, on a rising edge with rdy_in high, issue_en high and rob_full low, write entry[tail] (valid=1, ready=0, rd=issue_rd) and advance tail modulo DEPTH; issue_en with rob_full high SHALL be ignored even if a commit occurs that cycle.
REQ-012 SHALL, on wb_en with rdy_in high and entry[wb_tag] valid, store wb_val, wb_mispredict, wb_target and set ready; wb_en to an invalid entry SHALL be ignored.
REQ-013 SHALL, when entry[head] is valid and ready at a rising edge with rdy_in high, register commit_en=1, commit_Number=head, commit_val, commit_rd for exactly one cycle, invalidate head and advance head modulo DEPTH; at most one commit per cycle.
REQ-014 SHALL treat writeback to head as visible to commit no earlier than the following edge (one-cycle minimum writeback-to-commit latency).
REQ-015 SHALL, when the committing entry has mispredict=1, additionally register clear_o=1 and clear_pc=target for one cycle, and at the same edge invalidate all entries, set head=tail=count=0, and drop any simultaneous issue or writeback.
REQ-016 SHALL, on clear high with rdy_in high, flush as in REQ-015 without committing and without asserting clear_o.
REQ-017 SHALL update count by +1 on issue only, -1 on commit only, unchanged on both; wrap-around of head/tail SHALL be modulo DEPTH.
REQ-018 SHALL drive qryN_ready=1, qryN_val=entry value when entry[qryN_tag] is valid and ready; otherwise qryN_ready=0, qryN_val=0.
REQ-019 SHALL, with rdy_in low, hold all state and drive commit_en=0 and clear_o=0 at the next edge.

Reset
REQ-020 SHALL, on rst_in low at a rising edge, clear all valid bits, set head=tail=count=0, and drive commit_en=0, commit_Number=0, commit_val=0, commit_rd=0, clear_o=0, clear_pc=0; reset SHALL take priority over clear, commit and issue.
REQ-021 SHALL discard all in-flight entries if reset is asserted mid-operation; no commit SHALL be emitted for them.

Configuration
REQ-022 SHALL, with ROB_BYPASS_EN defined, also report qryN_ready=1, qryN_val=wb_val when wb_en is high and wb_tag==qryN_tag and the entry is valid (same-cycle forwarding).
REQ-023 SHALL, without ROB_BYPASS_EN, answer queries only from stored entry state.

Structure
REQ-024 SHALL take DEPTH default, tag width 5, data width 32 and the no-dependency tag sentinel from the shared definitions package, alongside the existing RS constants.
REQ-025 SHALL implement the operand lookup as one sub-module rob_query_port, instanced twice.

Verification
REQ-026 Reset: rst_in low one edge, then high -> rob_tag_o=0, rob_full=0, commit_en=0, clear_o=0.
REQ-027 In-order commit: issue rd=5,6,7 (tags 0,1,2); writeback tag2=0x30, tag0=0x10, tag1=0x20 -> commits tag0/0x10/rd5, tag1/0x20/rd6, tag2/0x30/rd7 on consecutive cycles.
REQ-028 Full/wrap: DEPTH=16, issue 16 -> rob_full=1, 17th issue ignored; commit 1, issue 1 -> new entry tag 0, rob_tag_o=1.
REQ-029 Mispredict: issue 3, writeback tag0 mispredict=1 target=0x1000 -> commit tag0 with clear_o=1, clear_pc=0x1000; next cycle rob_tag_o=0, count=0, tags 1-2 never commit.
REQ-030 Bypass: tag3 valid, wb_en tag3 val=0xABCD, qry1_tag=3 same cycle -> qry1_ready=1, qry1_val=0xABCD with ROB_BYPASS_EN; qry1_ready=0 without it.
REQ-031 Stall: head ready, rdy_in low 3 cycles -> no commit, state held; rdy_in high -> single commit.
